// File: rtl/issue_pkg.sv
// Shared issue-stage types and constants.
// - src_t / entry_t: renamed uop with two source operands (valid = operand ready).
// - write_req_t: issue queue write port payload {valid, entry}.
// - wake_req_t: result/retire broadcast {valid, preg id}.
// - snoop_src / snoop_entry: apply one cycle of wake/retire broadcasts to operands.
package issue_pkg;

  localparam int unsigned PREG_W       = 6;
  localparam int unsigned ALU_WAKE_NUM = 2;
  localparam int unsigned COMMIT_WIDTH = 2;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    logic  forward_en;
    preg_t pid;
  } src_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    preg_t       dst;
    src_t        src1;
    src_t        src2;
  } entry_t;

  typedef struct packed {
    logic   valid;
    entry_t entry;
  } write_req_t;

  typedef struct packed {
    logic  valid;
    preg_t id;
  } wake_req_t;

  typedef wake_req_t [ALU_WAKE_NUM-1:0] wake_vec_t;
  typedef wake_req_t [COMMIT_WIDTH-1:0] retire_vec_t;

  // A retired producer's value lives in the register file, so forwarding is
  // disabled even if an ALU wake hits the same operand in the same cycle.
  function automatic src_t snoop_src(input src_t src, input wake_vec_t wake,
                                     input retire_vec_t retire);
    src_t s;
    s = src;
    for (int unsigned j = 0; j < ALU_WAKE_NUM; j++) begin
      if (wake[j].valid && (wake[j].id == src.pid)) s.valid = 1'b1;
    end
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (retire[k].valid && (retire[k].id == src.pid)) begin
        s.valid      = 1'b1;
        s.forward_en = 1'b0;
      end
    end
    return s;
  endfunction

  function automatic entry_t snoop_entry(input entry_t e, input wake_vec_t wake,
                                         input retire_vec_t retire);
    entry_t r;
    r      = e;
    r.src1 = snoop_src(e.src1, wake, retire);
    r.src2 = snoop_src(e.src2, wake, retire);
    return r;
  endfunction

endpackage

// File: rtl/alu_dispatch_fifo.sv
// dispatch_fifo: DEPTH-entry circular buffer, DW-wide compacting enqueue, 1-wide dequeue.
// Ports:
// - clk        clock
// - clear      synchronous clear of head/tail/count (reset or flush)
// - enq_en     enqueue the valid lanes of enq_entry this cycle
// - enq_valid  per-lane valid; valid lanes are packed in lane order starting at tail
// - enq_entry  per-lane uop to store
// - deq_en     pop the head entry
// - upd_entry  next value for every stored slot (snooped copy of entries)
// - entries    raw storage, exposed for the snoop update and head read
// - head       head pointer
// - count      number of valid entries (0..DEPTH)
module dispatch_fifo
  import issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enq_en,
  input  logic [DW-1:0]      enq_valid,
  input  entry_t [DW-1:0]    enq_entry,
  input  logic               deq_en,
  input  entry_t [DEPTH-1:0] upd_entry,
  output entry_t [DEPTH-1:0] entries,
  output logic [AW-1:0]      head,
  output logic [CW-1:0]      count
);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      slot;
  logic [CW-1:0]      accepted;

  always_comb begin
    mem_d    = upd_entry;
    slot     = tail_q;
    accepted = '0;
    if (enq_en) begin
      for (int unsigned i = 0; i < DW; i++) begin
        if (enq_valid[i]) begin
          mem_d[slot] = enq_entry[i];
          slot        = slot + AW'(1);
          accepted    = accepted + CW'(1);
        end
      end
    end
    tail_d  = slot;
    head_d  = deq_en ? head_q + AW'(1) : head_q;
    count_d = count_q + accepted - CW'(deq_en);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign entries = mem_q;
  assign head    = head_q;
  assign count   = count_q;

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: buffers up to DW renamed uops per cycle and feeds them, oldest first, into the
// ALU issue queue's single write port, keeping operand readiness current via wake/retire snoop.
// Ports:
// - clk, reset  clock; synchronous active-high reset
// - flush       pipeline flush; empties the buffer at the next edge
// - in_valid    per-lane uop valid (lane 0 oldest)
// - in_entry    per-lane renamed uop
// - in_ready    buffer can take a full DW-lane group (registered state only)
// - wake        ALU result broadcasts
// - retire      ROB retire broadcasts
// - iq_full     issue queue has no free slot
// - wen         issue queue write enable
// - write       buffer head with current-cycle snoop applied
module alu_dispatch
  import issue_pkg::*;
#(
  parameter int unsigned DW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DW-1:0]     in_valid,
  input  entry_t [DW-1:0]   in_entry,
  output logic              in_ready,
  input  wake_vec_t         wake,
  input  retire_vec_t       retire,
  input  logic              iq_full,
  output logic              wen,
  output write_req_t        write
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ReadyMax = (AW + 1)'(DEPTH - DW);

  entry_t [DEPTH-1:0] entries, entries_snooped;
  entry_t [DW-1:0]    in_snooped;
  logic [AW-1:0]      head;
  logic [AW:0]        count;
  logic               empty, enq_en;

  // The queue snoops only what it has already stored, so whatever we hand it
  // must already include this cycle's broadcasts.
  always_comb begin
    for (int unsigned i = 0; i < DW; i++) begin
      in_snooped[i] = snoop_entry(in_entry[i], wake, retire);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_snooped[i] = snoop_entry(entries[i], wake, retire);
    end
  end

  always_comb begin
    empty       = (count == '0);
    in_ready    = (count <= ReadyMax);
    enq_en      = in_ready & ~flush & ~reset;
    // write.valid ignores iq_full so the queue's full logic cannot loop back.
    write.valid = ~empty;
    write.entry = entries_snooped[head];
    wen         = write.valid & ~iq_full & ~flush & ~reset;
  end

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .clear     (reset | flush),
    .enq_en    (enq_en),
    .enq_valid (in_valid),
    .enq_entry (in_snooped),
    .deq_en    (wen),
    .upd_entry (entries_snooped),
    .entries   (entries),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;
  import issue_pkg::*;

  localparam int unsigned DW    = 2;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, flush, iq_full, in_ready, wen;
  logic [DW-1:0]   in_valid;
  entry_t [DW-1:0] in_entry;
  wake_vec_t       wake;
  retire_vec_t     retire;
  write_req_t      write;

  always #5 clk = ~clk;

  alu_dispatch #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_entry (in_entry),
    .in_ready (in_ready),
    .wake     (wake),
    .retire   (retire),
    .iq_full  (iq_full),
    .wen      (wen),
    .write    (write)
  );

  int pass_cnt = 0;
  int total    = 0;

  // Reference model: ordered list of buffered uops, operands kept up to date.
  entry_t mq[$];

  function automatic entry_t m_snoop(input entry_t e);
    entry_t r = e;
    for (int j = 0; j < int'(ALU_WAKE_NUM); j++) begin
      if (wake[j].valid && wake[j].id == r.src1.pid) r.src1.valid = 1'b1;
      if (wake[j].valid && wake[j].id == r.src2.pid) r.src2.valid = 1'b1;
    end
    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      if (retire[k].valid && retire[k].id == r.src1.pid) begin
        r.src1.valid = 1'b1; r.src1.forward_en = 1'b0;
      end
      if (retire[k].valid && retire[k].id == r.src2.pid) begin
        r.src2.valid = 1'b1; r.src2.forward_en = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic bit exp_ready();
    return (int'(DEPTH) - mq.size()) >= int'(DW);
  endfunction

  function automatic bit exp_wen();
    return (mq.size() != 0) && !iq_full && !flush && !reset;
  endfunction

  function automatic entry_t rand_entry(input int unsigned pc);
    entry_t e;
    e.pc              = pc;
    e.op              = 4'($urandom);
    e.dst             = preg_t'($urandom);
    e.src1.valid      = 1'($urandom);
    e.src1.forward_en = 1'($urandom);
    e.src1.pid        = preg_t'($urandom_range(0, 15));
    e.src2.valid      = 1'($urandom);
    e.src2.forward_en = 1'($urandom);
    e.src2.pid        = preg_t'($urandom_range(0, 15));
    return e;
  endfunction

  task automatic idle_inputs();
    in_valid = '0;
    in_entry = '0;
    wake     = '0;
    retire   = '0;
    flush    = 1'b0;
    iq_full  = 1'b0;
  endtask

  // Advance one clock, updating the model with the inputs applied this cycle.
  task automatic tick();
    entry_t nq[$];
    bit rdy, pop;
    rdy = exp_ready();
    pop = exp_wen();
    if (!(reset || flush)) begin
      foreach (mq[i]) nq.push_back(m_snoop(mq[i]));
      if (pop) void'(nq.pop_front());
      if (rdy) begin
        for (int i = 0; i < int'(DW); i++) if (in_valid[i]) nq.push_back(m_snoop(in_entry[i]));
      end
    end
    @(posedge clk);
    mq = nq;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #4;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    total++;
    if (wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", wen);
    else pass_cnt++;
    total++;
    if (write.valid !== 1'b0) $display("FAIL reset_write_valid: got %b want 0", write.valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_burst();
    int groups = 0, run = 0, max_run = 0;
    int unsigned got[$];
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      in_valid = '0;
      if (groups < 3 && exp_ready()) begin
        in_valid    = 2'b11;
        in_entry[0] = rand_entry(32'(2 * groups));
        in_entry[1] = rand_entry(32'(2 * groups + 1));
        groups++;
      end
      #4;
      if (c == 1 || c == 2) begin
        total++;
        if (in_ready !== (c == 1))
          $display("FAIL burst_in_ready c=%0d: got %b want %b", c, in_ready, c == 1);
        else pass_cnt++;
      end
      total++;
      if (wen !== exp_wen()) $display("FAIL burst_wen c=%0d: got %b want %b", c, wen, exp_wen());
      else pass_cnt++;
      if (wen === 1'b1) begin
        got.push_back(write.entry.pc);
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      tick();
    end
    total++;
    if (max_run != 6) $display("FAIL burst_wen_run: got %0d want 6", max_run);
    else pass_cnt++;
    total++;
    if (got.size() != 6) $display("FAIL burst_count: got %0d want 6", got.size());
    else pass_cnt++;
    foreach (got[i]) begin
      total++;
      if (got[i] != i) $display("FAIL burst_order[%0d]: got %0d want %0d", i, got[i], i);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    iq_full = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid    = 2'b11;
      in_entry[0] = rand_entry(32'(10 + 2 * g));
      in_entry[1] = rand_entry(32'(11 + 2 * g));
      tick();
    end
    in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #4;
      total++;
      if (wen !== 1'b0 || in_ready !== 1'b0 || write.valid !== 1'b1)
        $display("FAIL bp_hold c=%0d: got wen=%b rdy=%b val=%b want 0 0 1",
                 c, wen, in_ready, write.valid);
      else pass_cnt++;
      tick();
    end
    iq_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      total++;
      if (wen !== 1'b1 || write.entry.pc !== 32'(10 + i))
        $display("FAIL bp_release[%0d]: got wen=%b pc=%0d want 1 %0d",
                 i, wen, write.entry.pc, 10 + i);
      else pass_cnt++;
      tick();
    end
    #4;
    total++;
    if (write.valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", write.valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_bypass();
    entry_t e;
    idle_inputs();
    e            = rand_entry(50);
    e.src1.pid   = 7;
    e.src1.valid = 1'b0;
    e.src2.pid   = 9;
    iq_full      = 1'b1;
    in_valid     = 2'b01;
    in_entry[0]  = e;
    tick();
    in_valid = '0;
    #4;
    total++;
    if (write.entry.src1.valid !== 1'b0)
      $display("FAIL bypass_before: got %b want 0", write.entry.src1.valid);
    else pass_cnt++;
    tick();
    iq_full = 1'b0;
    wake[0] = '{valid: 1'b1, id: 6'd7};
    #4;
    total++;
    if (wen !== 1'b1 || write.entry.pc !== 32'd50 || write.entry.src1.valid !== 1'b1)
      $display("FAIL bypass_wake: got wen=%b pc=%0d src1.valid=%b want 1 50 1",
               wen, write.entry.pc, write.entry.src1.valid);
    else pass_cnt++;
    tick();
    wake = '0;
  endtask

  task automatic test_retire();
    entry_t e;
    idle_inputs();
    e                 = rand_entry(60);
    e.src1.pid        = 3;
    e.src2.pid        = 12;
    e.src2.valid      = 1'b0;
    e.src2.forward_en = 1'b1;
    iq_full           = 1'b1;
    in_valid          = 2'b01;
    in_entry[0]       = e;
    tick();
    in_valid  = '0;
    retire[1] = '{valid: 1'b1, id: 6'd12};
    tick();
    retire  = '0;
    iq_full = 1'b0;
    #4;
    total++;
    if (wen !== 1'b1 || write.entry.pc !== 32'd60 || write.entry.src2.valid !== 1'b1 ||
        write.entry.src2.forward_en !== 1'b0 ||
        write.entry.src1.forward_en !== e.src1.forward_en)
      $display("FAIL retire_snoop: got wen=%b pc=%0d s2v=%b s2f=%b s1f=%b want 1 60 1 0 %b",
               wen, write.entry.pc, write.entry.src2.valid, write.entry.src2.forward_en,
               write.entry.src1.forward_en, e.src1.forward_en);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    iq_full     = 1'b1;
    in_valid    = 2'b11;
    in_entry[0] = rand_entry(70);
    in_entry[1] = rand_entry(71);
    tick();
    in_valid    = 2'b01;
    in_entry[0] = rand_entry(72);
    tick();
    iq_full     = 1'b0;
    flush       = 1'b1;
    in_valid    = 2'b11;
    in_entry[0] = rand_entry(73);
    in_entry[1] = rand_entry(74);
    #4;
    total++;
    if (wen !== 1'b0) $display("FAIL flush_wen: got %b want 0", wen);
    else pass_cnt++;
    tick();
    flush    = 1'b0;
    in_valid = '0;
    for (int c = 0; c < 2; c++) begin
      #4;
      total++;
      if (in_ready !== 1'b1 || write.valid !== 1'b0 || wen !== 1'b0)
        $display("FAIL flush_after c=%0d: got rdy=%b val=%b wen=%b want 1 0 0",
                 c, in_ready, write.valid, wen);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    for (int i = 0; i <= 10; i++) begin
      in_valid = '0;
      if (i < 10) begin
        in_valid    = 2'b01;
        in_entry[0] = rand_entry(32'(200 + i));
      end
      #4;
      if (i > 0) begin
        total++;
        if (wen !== 1'b1 || write.entry.pc !== 32'(199 + i))
          $display("FAIL wrap[%0d]: got wen=%b pc=%0d want 1 %0d", i, wen, write.entry.pc, 199 + i);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    int unsigned pc = 1000;
    entry_t exp_e;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      in_valid = '0;
      if (exp_ready()) in_valid = DW'($urandom);
      for (int i = 0; i < int'(DW); i++) begin
        in_entry[i] = rand_entry(pc);
        pc++;
      end
      iq_full = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 29) == 0);
      for (int j = 0; j < int'(ALU_WAKE_NUM); j++)
        wake[j] = '{valid: 1'($urandom_range(0, 1)), id: preg_t'($urandom_range(0, 15))};
      for (int k = 0; k < int'(COMMIT_WIDTH); k++)
        retire[k] = '{valid: 1'($urandom_range(0, 2) == 0), id: preg_t'($urandom_range(0, 15))};
      #4;
      total++;
      if (in_ready !== exp_ready() || write.valid !== (mq.size() != 0) || wen !== exp_wen())
        $display("FAIL rand_ctrl c=%0d: got rdy=%b val=%b wen=%b want %b %b %b", c, in_ready,
                 write.valid, wen, exp_ready(), mq.size() != 0, exp_wen());
      else pass_cnt++;
      if (mq.size() != 0) begin
        exp_e = m_snoop(mq[0]);
        total++;
        if (write.entry !== exp_e)
          $display("FAIL rand_entry c=%0d: got %h want %h", c, write.entry, exp_e);
        else pass_cnt++;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_burst();
    test_backpressure();
    test_bypass();
    test_retire();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
